fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation RV32I core.
//  Replaces the in-core PC register and PC+4 adder with an owned fetch PC.
//  Supports a variable-latency IMEM with a req/gnt/rvalid handshake, up to FIFO_DEPTH
//  outstanding requests, and an in-order {PC, instruction} prefetch queue.
//  Branch/jump redirects flush the queue and discard stale in-flight responses.
// PARAMETERS
//  XLEN          32   address/PC width
//  RESET_VECTOR  0    fetch PC loaded on reset (bits [1:0] must be 0)
//  FIFO_DEPTH    4    queue entries = max outstanding + buffered; power of 2, >=2
// PORTS
//  CLK          in   1     clock, all state on rising edge
//  RESET        in   1     asynchronous reset, active-high
//  IMEM_REQ     out  1     fetch request valid
//  IMEM_ADDR    out  XLEN  fetch address, word aligned
//  IMEM_GNT     in   1     IMEM accepts request this cycle (REQ&&GNT = issue)
//  IMEM_RVALID  in   1     read data valid; responses return in issue order
//  IMEM_RDATA   in   32    instruction word
//  REDIRECT     in   1     flush and restart fetch at REDIRECT_PC
//  REDIRECT_PC  in   XLEN  new fetch PC; bits [1:0] forced to 0 internally
//  INSTR_VALID  out  1     queue head valid
//  INSTR        out  32    queue head instruction
//  INSTR_PC     out  XLEN  PC of queue head
//  INSTR_READY  in   1     consumer takes head (VALID&&READY = pop)
// BEHAVIOUR
//  - State: FPC (next fetch addr), RPC (PC of next response), OUTST (in flight),
//    DROP (stale in flight), CNT (queue occupancy). Counters are clog2(FIFO_DEPTH)+1 bits.
//  - Reset (async, RESET=1):
//    - FPC=RPC=RESET_VECTOR; OUTST=DROP=CNT=0.
//    - IMEM_REQ=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0.
//    - Applies mid-transaction; responses already in flight are not tracked after reset.
//  - Credit: IMEM_REQ = !RESET && !REDIRECT && (OUTST+CNT < FIFO_DEPTH). IMEM_ADDR=FPC.
//  - Request hold: while REQ && !GNT, IMEM_ADDR is held. On issue, FPC += 4 and OUTST += 1.
//    FPC wraps modulo 2^XLEN.
//  - Response:
//    - IMEM_RVALID with DROP>0: data discarded, DROP -= 1, OUTST -= 1.
//    - Otherwise push {RPC, IMEM_RDATA}, RPC += 4, OUTST -= 1.
//    - RVALID with OUTST==0 is a protocol error; it is ignored and changes no state.
//  - Output: head is registered. INSTR_VALID = (CNT!=0). INSTR/INSTR_PC are stable while
//    VALID && !READY. Push and pop in the same cycle leave CNT unchanged.
//  - Latency: issue in cycle N, RVALID in cycle N+k; INSTR_VALID=1 in cycle N+k+1.
//    Back-to-back throughput is 1 instr/cycle when GNT, RVALID and READY are all held at 1.
//  - Full/empty: credit guarantees no overflow, so a response always has a slot.
//    Pop when CNT==0 is a no-op.
//  - REDIRECT (takes priority over every other event in that cycle):
//    - CNT <= 0; the pop in that cycle is ignored. INSTR_VALID=0 next cycle.
//    - FPC <= RPC <= {REDIRECT_PC[XLEN-1:2],2'b00}.
//    - DROP <= (OUTST - rv_this_cycle); OUTST is likewise reduced by any response in
//      that cycle. A response arriving in the redirect cycle is discarded.
//    - No issue in the redirect cycle. Fetch resumes next cycle, subject to credit:
//      OUTST still counts stale requests.
//    - Back-to-back redirects: the last one wins. DROP accumulates correctly because it
//      always equals the stale portion of OUTST.
// TESTING
//  1. Reset, GNT=1, RVALID one cycle after each issue, READY=1 -> ADDR 0,4,8,C on
//     consecutive cycles; INSTR_PC 0,4,8 in order. First INSTR_VALID 2 cycles after the
//     first issue.
//  2. FIFO_DEPTH=4, READY=0, GNT=1, RVALID=1 -> 4 issues, then REQ=0. CNT=4, head
//     PC=0 held. Raise READY -> one pop per cycle and REQ re-asserts.
//  3. GNT=0 for 3 cycles with REQ=1 -> IMEM_ADDR stays 0x00000000; FPC advances only
//     after the GNT cycle.
//  4. 3 requests in flight, REDIRECT=1 with REDIRECT_PC=0x103 -> next cycle queue empty,
//     ADDR=0x100. The 3 old responses are dropped; the first INSTR_PC out is 0x100.
//  5. REDIRECT and RVALID in the same cycle, 1 outstanding -> response dropped, DROP=0,
//     no stale instruction delivered.
//  6. Async RESET pulse mid-burst, between clock edges -> REQ and INSTR_VALID fall
//     immediately; after release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues IMEM requests under a
// credit limit and buffers {PC, instruction} pairs in an in-order queue.
module fetch_queue_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_INC  = XLEN'(4);

  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_rpc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [XLEN-1:0] r_pc_mem  [FIFO_DEPTH];
  logic [31:0]     r_ins_mem [FIFO_DEPTH];

  logic [CW:0]     w_used;
  logic            w_credit;
  logic            w_issue;
  logic            w_rv;
  logic            w_drop_rsp;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;

  // In-flight requests consume queue slots so every response is guaranteed a home.
  assign w_used     = {1'b0, r_outst} + {1'b0, r_cnt};
  assign w_credit   = (w_used < DEPTH_C);
  assign o_imem_req = !i_rst && !i_redirect && w_credit;
  assign o_imem_addr = r_fpc;

  assign w_issue    = o_imem_req && i_imem_gnt;
  assign w_rv       = i_imem_rvalid && (r_outst != '0);
  assign w_drop_rsp = w_rv && (r_drop != '0);
  assign w_push     = w_rv && (r_drop == '0) && !i_redirect;
  assign w_pop      = o_instr_valid && i_instr_ready && !i_redirect;

  assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);

  assign o_instr_valid = (r_cnt != '0);
  assign o_instr       = o_instr_valid ? r_ins_mem[r_rd_ptr] : 32'h0;
  assign o_instr_pc    = o_instr_valid ? r_pc_mem[r_rd_ptr]  : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fpc    <= RESET_VECTOR;
      r_rpc    <= RESET_VECTOR;
      r_outst  <= '0;
      r_drop   <= '0;
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_redirect) begin
      // Everything still in flight becomes stale, minus a response landing now.
      r_fpc    <= w_redirect_pc;
      r_rpc    <= w_redirect_pc;
      r_outst  <= r_outst - CW'(w_rv);
      r_drop   <= r_outst - CW'(w_rv);
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_issue) r_fpc <= r_fpc + PC_INC;
      if (w_push) begin
        r_rpc    <= r_rpc + PC_INC;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_outst <= r_outst + CW'(w_issue) - CW'(w_rv);
      r_drop  <= r_drop - CW'(w_drop_rsp);
      r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_rpc;
      r_ins_mem[r_wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: in-order delivery, credit stall, grant hold,
// redirect flush with stale-response drop, and asynchronous reset.
module tb_fetch_queue_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ivalid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ready;

  logic        auto_rsp;
  int          n_chk;
  int          n_pass;

  fetch_queue_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_valid (ivalid),
    .o_instr       (instr),
    .o_instr_pc    (ipc),
    .i_instr_ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // One clock; in auto mode the IMEM answers each issue one cycle later with
  // data {16'hC0DE, addr[15:0]}.
  task automatic tick();
    logic        pend;
    logic [31:0] pa;
    #1;
    pend = auto_rsp && req && gnt;
    pa   = addr;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      rvalid = pend;
      rdata  = pend ? {16'hC0DE, pa[15:0]} : 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if (!auto_rsp) rvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1; auto_rsp = 1'b1;

    // Reset state and in-order stream
    tick();
    check_eq("rst_req", {31'b0, req}, 32'h0);
    check_eq("rst_valid", {31'b0, ivalid}, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_pc", ipc, 32'h0);
    do_reset();
    check_eq("t1_c0_req", {31'b0, req}, 32'h1);
    check_eq("t1_c0_addr", addr, 32'h0);
    tick();
    check_eq("t1_c1_addr", addr, 32'h4);
    check_eq("t1_c1_valid", {31'b0, ivalid}, 32'h0);
    tick();
    check_eq("t1_c2_addr", addr, 32'h8);
    check_eq("t1_c2_valid", {31'b0, ivalid}, 32'h1);
    check_eq("t1_c2_pc", ipc, 32'h0);
    check_eq("t1_c2_instr", instr, 32'hC0DE0000);
    tick();
    check_eq("t1_c3_addr", addr, 32'hC);
    check_eq("t1_c3_pc", ipc, 32'h4);
    check_eq("t1_c3_instr", instr, 32'hC0DE0004);
    tick();
    check_eq("t1_c4_pc", ipc, 32'h8);

    // Credit stall with consumer blocked
    ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check_eq("t2_full_req", {31'b0, req}, 32'h0);
    check_eq("t2_full_addr", addr, 32'h10);
    check_eq("t2_full_valid", {31'b0, ivalid}, 32'h1);
    check_eq("t2_full_pc", ipc, 32'h0);
    check_eq("t2_full_instr", instr, 32'hC0DE0000);
    tick();
    check_eq("t2_hold_pc", ipc, 32'h0);
    check_eq("t2_hold_req", {31'b0, req}, 32'h0);
    ready = 1'b1;
    tick();
    check_eq("t2_pop1_pc", ipc, 32'h4);
    check_eq("t2_pop1_req", {31'b0, req}, 32'h1);
    tick();
    check_eq("t2_pop2_pc", ipc, 32'h8);

    // Grant withheld: address held
    gnt = 1'b0;
    do_reset();
    check_eq("t3_c0_addr", addr, 32'h0);
    check_eq("t3_c0_req", {31'b0, req}, 32'h1);
    tick();
    check_eq("t3_c1_addr", addr, 32'h0);
    tick();
    check_eq("t3_c2_addr", addr, 32'h0);
    gnt = 1'b1;
    tick();
    check_eq("t3_c3_addr", addr, 32'h4);
    gnt = 1'b0;
    tick();
    check_eq("t3_c4_addr", addr, 32'h4);

    // Redirect with 3 requests in flight
    auto_rsp = 1'b0; gnt = 1'b1; ready = 1'b1;
    do_reset();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    check_eq("t4_redir_req", {31'b0, req}, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("t4_c4_req", {31'b0, req}, 32'h1);
    check_eq("t4_c4_addr", addr, 32'h100);
    check_eq("t4_c4_valid", {31'b0, ivalid}, 32'h0);
    rvalid = 1'b1; rdata = 32'hDEAD0000;
    tick();
    gnt = 1'b0; rdata = 32'hDEAD0004;
    check_eq("t4_c5_valid", {31'b0, ivalid}, 32'h0);
    tick();
    rdata = 32'hDEAD0008;
    check_eq("t4_c6_valid", {31'b0, ivalid}, 32'h0);
    tick();
    rdata = 32'h11110100;
    check_eq("t4_c7_valid", {31'b0, ivalid}, 32'h0);
    tick();
    rvalid = 1'b0;
    check_eq("t4_c8_valid", {31'b0, ivalid}, 32'h1);
    check_eq("t4_c8_pc", ipc, 32'h100);
    check_eq("t4_c8_instr", instr, 32'h11110100);
    tick();
    check_eq("t4_c9_valid", {31'b0, ivalid}, 32'h0);

    // Redirect coinciding with the only response; then a stray RVALID
    gnt = 1'b1;
    do_reset();
    tick();
    gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; rvalid = 1'b1; rdata = 32'h0BAD0000;
    tick();
    redirect = 1'b0; rvalid = 1'b0;
    #1;
    check_eq("t5_c2_valid", {31'b0, ivalid}, 32'h0);
    check_eq("t5_c2_req", {31'b0, req}, 32'h1);
    check_eq("t5_c2_addr", addr, 32'h200);
    rvalid = 1'b1; rdata = 32'h00BADBAD;
    tick();
    rvalid = 1'b0;
    check_eq("t5_stray_valid", {31'b0, ivalid}, 32'h0);
    check_eq("t5_stray_addr", addr, 32'h200);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h22220200;
    check_eq("t5_c4_addr", addr, 32'h204);
    tick();
    rvalid = 1'b0;
    check_eq("t5_c5_valid", {31'b0, ivalid}, 32'h1);
    check_eq("t5_c5_pc", ipc, 32'h200);
    check_eq("t5_c5_instr", instr, 32'h22220200);

    // Asynchronous reset mid-burst
    auto_rsp = 1'b1; gnt = 1'b1; ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    check_eq("t6_pre_valid", {31'b0, ivalid}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_req", {31'b0, req}, 32'h0);
    check_eq("t6_rst_valid", {31'b0, ivalid}, 32'h0);
    check_eq("t6_rst_instr", instr, 32'h0);
    check_eq("t6_rst_pc", ipc, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("t6_rel_req", {31'b0, req}, 32'h1);
    check_eq("t6_rel_addr", addr, 32'h0);
    tick();
    check_eq("t6_c1_addr", addr, 32'h4);
    check_eq("t6_c1_valid", {31'b0, ivalid}, 32'h0);
    tick();
    check_eq("t6_c2_valid", {31'b0, ivalid}, 32'h1);
    check_eq("t6_c2_pc", ipc, 32'h0);
    check_eq("t6_c2_instr", instr, 32'hC0DE0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
